// File: rtl/stream_xor_encoder_if.sv
// Stream/control bundle for stream_xor_encoder; master is the encoder side.
// The checksum wire exists only when STREAM_XOR_CHECKSUM_EN is defined.
interface stream_xor_encoder_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_WORDS = 24
);
    logic                       start;
    logic [NUM_WORDS*WIDTH-1:0] in;
    logic [WIDTH-1:0]           key;
    logic                       mode;
    logic [WIDTH-1:0]           out;
    logic                       out_valid;
    logic                       out_ready;
    logic                       busy;
    logic                       done;
`ifdef STREAM_XOR_CHECKSUM_EN
    logic [WIDTH-1:0]           checksum;

    modport master (
        input  start, in, key, mode, out_ready,
        output out, out_valid, busy, done, checksum
    );
    modport slave (
        output start, in, key, mode, out_ready,
        input  out, out_valid, busy, done, checksum
    );
`else
    modport master (
        input  start, in, key, mode, out_ready,
        output out, out_valid, busy, done
    );
    modport slave (
        output start, in, key, mode, out_ready,
        input  out, out_valid, busy, done
    );
`endif
endinterface

// File: rtl/stream_xor_encoder.sv
// Word-serial XOR encoder: captures a packed block and streams it LSB word first,
// fixed or chained (ciphertext feedback) key. STREAM_XOR_CHECKSUM_EN adds an XOR checksum.
module stream_xor_encoder #(
    parameter int WIDTH     = 8,
    parameter int NUM_WORDS = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    stream_xor_encoder_if.master  bus
);
    // NUM_WORDS must be at least 2 so the index counter has a nonzero width.
    localparam int IDX_W = $clog2(NUM_WORDS);

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t                     state, state_next;
    logic [NUM_WORDS*WIDTH-1:0] block_reg, block_next;
    logic [WIDTH-1:0]           key_reg, key_next;
    logic [WIDTH-1:0]           out_reg, out_next;
    logic                       mode_reg, mode_next;
    logic [IDX_W-1:0]           idx, idx_next;
    logic                       out_valid_reg, out_valid_next;
    logic                       busy_reg, busy_next;
    logic                       done_reg, done_next;

    logic [WIDTH-1:0]           words [NUM_WORDS];
    logic [IDX_W-1:0]           idx_inc;
    logic [WIDTH-1:0]           step_key;
    logic                       fire;

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_words
        assign words[k] = block_reg[k*WIDTH +: WIDTH];
    end

    assign fire     = out_valid_reg && bus.out_ready;
    assign idx_inc  = idx + IDX_W'(1);
    // Chained mode feeds the word just emitted back in as the next key.
    assign step_key = mode_reg ? out_reg : key_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            block_reg     <= '0;
            key_reg       <= '0;
            mode_reg      <= 1'b0;
            idx           <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state         <= state_next;
            block_reg     <= block_next;
            key_reg       <= key_next;
            mode_reg      <= mode_next;
            idx           <= idx_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        block_next     = block_reg;
        key_next       = key_reg;
        mode_next      = mode_reg;
        idx_next       = idx;
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                out_valid_next = 1'b0;
                busy_next      = 1'b0;
                if (bus.start) begin
                    block_next     = bus.in;
                    key_next       = bus.key;
                    mode_next      = bus.mode;
                    idx_next       = '0;
                    out_next       = bus.in[WIDTH-1:0] ^ bus.key;
                    out_valid_next = 1'b1;
                    busy_next      = 1'b1;
                    state_next     = RUN;
                end
            end
            RUN: begin
                if (fire) begin
                    if (idx == IDX_W'(NUM_WORDS - 1)) begin
                        out_valid_next = 1'b0;
                        busy_next      = 1'b0;
                        done_next      = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        idx_next = idx_inc;
                        key_next = step_key;
                        out_next = words[idx_inc] ^ step_key;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.out       = out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;

`ifdef STREAM_XOR_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_reg;

    // Cleared on block acceptance, then folds in each word as it is handed off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_reg <= '0;
        end else if (state == IDLE && bus.start) begin
            checksum_reg <= '0;
        end else if (state == RUN && fire) begin
            checksum_reg <= checksum_reg ^ out_reg;
        end
    end

    assign bus.checksum = checksum_reg;
`endif
endmodule

// File: tb/tb_stream_xor_encoder.sv
// Directed bench for stream_xor_encoder: fixed/chained keys, backpressure,
// ignored mid-block inputs, back-to-back start, async reset, optional checksum.
module tb_stream_xor_encoder;
    localparam int WIDTH     = 8;
    localparam int NUM_WORDS = 24;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [NUM_WORDS*WIDTH-1:0] block;
    logic [WIDTH-1:0]           plain     [NUM_WORDS];
    logic [WIDTH-1:0]           exp_fixed [NUM_WORDS];
    logic [WIDTH-1:0]           exp_chain [NUM_WORDS];
    logic [WIDTH-1:0]           exp_sum;

    stream_xor_encoder_if #(.WIDTH(WIDTH), .NUM_WORDS(NUM_WORDS)) bus ();

    stream_xor_encoder #(.WIDTH(WIDTH), .NUM_WORDS(NUM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic s, input logic [WIDTH-1:0] k, input logic m);
        bus.start = s;
        bus.key   = k;
        bus.mode  = m;
    endtask

    task automatic check_output(input string tag, input logic [WIDTH-1:0] observed,
                                input logic [WIDTH-1:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
        end
    endtask

    initial begin
        exp_sum = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            plain[k]              = 8'h41 + 8'(k);
            block[k*WIDTH +: WIDTH] = plain[k];
            exp_fixed[k]          = plain[k] ^ 8'h5A;
            exp_chain[k]          = plain[k] ^ ((k == 0) ? 8'h5A : exp_chain[k-1]);
            exp_sum               = exp_sum ^ exp_fixed[k];
        end

        // Reset held with start high: nothing may start
        bus.in        = block;
        bus.out_ready = 1'b1;
        apply_stimulus(1'b1, 8'h5A, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        check_output("rst_out", bus.out, 8'h00);
        check_bit("rst_valid", bus.out_valid, 1'b0);
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bit("rst_done", bus.done, 1'b0);

        bus.start = 1'b0;
        reset     = 1'b0;
        tick();
        check_bit("post_rst_valid", bus.out_valid, 1'b0);
        check_bit("post_rst_busy", bus.busy, 1'b0);

        // Fixed-key block, full-rate consumer
        apply_stimulus(1'b1, 8'h5A, 1'b0);
        tick();
        bus.start = 1'b0;
        check_output("fixed_w0_hand", bus.out, 8'h1B);
        check_bit("fixed_busy", bus.busy, 1'b1);
        for (int k = 0; k < NUM_WORDS; k++) begin
            check_bit("fixed_valid", bus.out_valid, 1'b1);
            check_output("fixed_word", bus.out, exp_fixed[k]);
            if (k == 1) check_output("fixed_w1_hand", bus.out, 8'h18);
            tick();
        end
        check_bit("fixed_done", bus.done, 1'b1);
        check_bit("fixed_end_valid", bus.out_valid, 1'b0);
        check_bit("fixed_end_busy", bus.busy, 1'b0);
        check_output("fixed_out_hold", bus.out, exp_fixed[NUM_WORDS-1]);
        tick();
        check_bit("fixed_done_pulse", bus.done, 1'b0);

        // Chained-key block with a stall at idx 3 and ignored start/key/in at idx 6
        apply_stimulus(1'b1, 8'h5A, 1'b1);
        tick();
        bus.start = 1'b0;
        check_output("chain_w0_hand", bus.out, 8'h1B);
        for (int k = 0; k < NUM_WORDS; k++) begin
            check_bit("chain_valid", bus.out_valid, 1'b1);
            check_output("chain_word", bus.out, exp_chain[k]);
            if (k == 1) check_output("chain_w1_hand", bus.out, 8'h59);
            if (k == 3) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check_output("stall_out", bus.out, exp_chain[3]);
                    check_bit("stall_valid", bus.out_valid, 1'b1);
                    check_bit("stall_busy", bus.busy, 1'b1);
                end
                bus.out_ready = 1'b1;
            end
            if (k == 6) begin
                apply_stimulus(1'b1, 8'hFF, 1'b0);
                bus.in = ~block;
            end
            if (k == 7) bus.start = 1'b0;
            tick();
        end
        check_bit("chain_done", bus.done, 1'b1);

        // Start during the done cycle: next block begins one cycle later
        apply_stimulus(1'b1, 8'h5A, 1'b0);
        bus.in = block;
        tick();
        bus.start = 1'b0;
        check_bit("b2b_done_low", bus.done, 1'b0);
        check_bit("b2b_valid", bus.out_valid, 1'b1);
        check_output("b2b_w0", bus.out, 8'h1B);

        // Run to idx 10, then reset asynchronously between clock edges
        for (int k = 0; k <= 10; k++) begin
            check_output("pre_abort_word", bus.out, exp_fixed[k]);
            if (k < 10) tick();
        end
        #1 reset = 1'b1;
        #1;
        check_output("abort_out", bus.out, 8'h00);
        check_bit("abort_valid", bus.out_valid, 1'b0);
        check_bit("abort_busy", bus.busy, 1'b0);
        check_bit("abort_done", bus.done, 1'b0);
        tick();
        tick();
        check_bit("abort_no_done", bus.done, 1'b0);
        reset = 1'b0;
        tick();
        check_bit("abort_idle_valid", bus.out_valid, 1'b0);

        // Final fixed block; checksum checked when the feature is built in
        apply_stimulus(1'b1, 8'h5A, 1'b0);
        tick();
        bus.start = 1'b0;
        repeat (NUM_WORDS) tick();
        check_bit("final_done", bus.done, 1'b1);
        check_output("final_last", bus.out, exp_fixed[NUM_WORDS-1]);
`ifdef STREAM_XOR_CHECKSUM_EN
        check_output("checksum", bus.checksum, exp_sum);
        tick();
        check_output("checksum_hold", bus.checksum, exp_sum);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/stream_xor_encoder.md
Name: stream_xor_encoder

Overview:
Parametrised successor to the single-key byte-slice encoder. Captures a packed block of NUM_WORDS words, then emits them LSB-word-first, one per accepted handshake, each XORed with a key. Two key modes are supported: fixed key, or chained key (ciphertext feedback). A valid/ready output stream and start/busy/done control let the block sit between a packed-register producer and a word-serial consumer such as a checker or UART.

Parameters:
WIDTH, 8, bits per word and per key
NUM_WORDS, 24, words per block; must be >= 2
IDX_W, $clog2(NUM_WORDS), word-index counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a block; sampled only in IDLE
in  input  NUM_WORDS*WIDTH  packed block; word k = in[k*WIDTH +: WIDTH]
key  input  WIDTH  initial key, captured with start
mode  input  1  0 = fixed key, 1 = chained key; captured with start
out  output  WIDTH  encoded word
out_valid  output  1  out holds a valid word
out_ready  input  1  consumer accepts out this cycle
busy  output  1  high from start acceptance until the final word is accepted
done  output  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (async, active-high, any state): state=IDLE; out=0, out_valid=0, busy=0, done=0; index, key register, mode register and block register all cleared. A reset mid-block abandons the block with no done pulse.
- States: IDLE, RUN.
- IDLE, start=1: capture in, key and mode into registers. Next cycle: state=RUN, busy=1, out_valid=1, out=word0^key, idx=0. Latency from start to first valid word is 1 cycle.
- IDLE, start=0: hold. out_valid=0 and busy=0; out retains its last value.
- RUN: a handshake fires when out_valid && out_ready.
  - No handshake: out, out_valid, idx and the key register are held stable. Backpressure may last any number of cycles.
  - Handshake with idx < NUM_WORDS-1: idx += 1; key register updates per mode; out <= word[idx+1] ^ next key. Back-to-back handshakes sustain 1 word/cycle.
  - Handshake with idx == NUM_WORDS-1: out_valid <= 0, busy <= 0, done <= 1 for exactly one cycle, state=IDLE. out keeps the final word.
- Key update:
  - mode 0: key is constant for the whole block.
  - mode 1: next key = the word just emitted (ciphertext), i.e. c[k] = p[k] ^ c[k-1], with c[-1] = key.
- All XORs are WIDTH bits wide with no carries. The index never exceeds NUM_WORDS-1, so no wrap-around is possible.
- start while RUN is ignored; in, key and mode changes during RUN have no effect.
- start asserted in the same cycle done is high (state already IDLE) is accepted normally, giving back-to-back blocks with a one-cycle gap in out_valid.

Optional Feature:
Macro STREAM_XOR_CHECKSUM_EN.
- Defined: adds output port checksum [WIDTH-1:0]. It is cleared at start acceptance and XOR-accumulates every emitted out word on its handshake. It is valid and stable from the done cycle until the next start acceptance. Reset value 0.
- Undefined: no checksum port and no accumulator logic; behaviour is otherwise identical.

Test Plan:
- Reset: hold reset with start=1 -> out=0, out_valid=0, busy=0, done=0. Release reset -> block starts only on a subsequent start sample.
- Fixed mode: WIDTH=8, NUM_WORDS=24, word0=0x41, word1=0x42, key=0x5A, mode=0, out_ready=1 -> out=0x1B then 0x18. 24 consecutive valid cycles, done pulse on the cycle after the 24th handshake.
- Chained mode: same data, mode=1 -> out=0x1B, then 0x42^0x1B=0x59, each subsequent word XORed with the prior output.
- Backpressure: drop out_ready for 5 cycles at idx=3 -> out and idx unchanged throughout; the stream resumes with no word lost or duplicated.
- Ignored inputs: pulse start and change key mid-RUN -> output sequence unaffected. Assert start in the done cycle -> second block accepted with a correct first word.
- Reset mid-block at idx=10 -> all outputs 0 immediately (asynchronously), no done pulse. With STREAM_XOR_CHECKSUM_EN defined, a full fixed-mode block gives checksum = XOR of all 24 emitted words.
